enemy_plotter: RTL and testbench
================================

Name: enemy_plotter

Overview:
- Consumer side of the enemy coordinate/visibility bus: takes per-plane x, y and colour from the enemy controller and rasterises each plane as a SPR_W x SPR_H block into the VGA adapter write port.
- Runs one draw pass or one erase pass per start pulse and answers with a one-cycle done, which the controller's S_DRAW/S_ERASE states wait on.
- Erase reuses the snapshot taken at the last draw, so the controller may update y between the draw and erase passes.

Parameters:
- N_PLANES, 10, number of enemy planes on the bus.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 4, sprite height in pixels.
- X_MAX, 160, screen width; pixels with x >= X_MAX are clipped.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are clipped.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- erase  in  1  pass type, sampled with start: 0 = draw, 1 = erase
- x_flat  in  8*N_PLANES  plane i x in bits [8i+7:8i]
- y_flat  in  8*N_PLANES  plane i y in bits [8i+7:8i]
- vis_flat  in  3*N_PLANES  plane i colour in bits [3i+2:3i]; 000 = not present
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse at the end of a pass
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  write strobe to the VGA adapter

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clk.
- Reset state: IDLE, with busy, done, plot, vga_x, vga_y and vga_colour all 0, and the snapshot cleared (all vis = 000).
- Reset asserted mid-pass aborts the pass at once. No done is issued, and plot is 0 in the following cycle.
- States:
  - IDLE: on start=1 go to LOAD with plane index i=0, and latch erase.
  - When erase=0, copy x_flat, y_flat and vis_flat into the snapshot registers in that same edge.
  - When erase=1, keep the existing snapshot.
  - LOAD (1 cycle): if snapshot vis[i] == 000, skip the plane: go to LOAD i+1, or to DONE after the last plane.
  - Otherwise clear dx and dy, then go to PLOT.
  - PLOT (SPR_W*SPR_H cycles): emit one pixel per cycle in row-major order, dx fastest.
  - After the pixel with dx=SPR_W-1 and dy=SPR_H-1, go to LOAD i+1, or to DONE when i = N_PLANES-1.
  - DONE (1 cycle): done=1, busy=1, then return to IDLE.
- Pixel outputs in PLOT, decoded from registered state:
  - vga_x = x_i+dx, truncated to 8 bits.
  - vga_y = y_i+dy, truncated to 7 bits.
  - vga_colour = 000 when erase, else vis_i.
- Clipping: compute the bounds test on 9-bit sums. plot = 1 only if (x_i+dx) < X_MAX and (y_i+dy) < Y_MAX.
- A clipped pixel still consumes its cycle, so pass timing depends only on the visible count.
- Outside PLOT, plot=0 and vga_x, vga_y and vga_colour are held at 0.
- Timing: start is sampled at edge 0. With v non-black planes, done is high in cycle N_PLANES + 16v + 1 (SPR 4x4).
- Erase pass timing equals the preceding draw pass timing.
- start during busy is ignored; it is not queued.
- start and reset in the same cycle: reset wins.
- An erase with no prior draw since reset erases nothing, because every snapshot vis is 000.
- No pixel handshake: the VGA adapter accepts one pixel per cycle.

Decomposition:
- Shared package (enemy_pkg): COLOUR_BLACK=3'b000, COLOUR_WHITE=3'b111, SCREEN_W=160, SCREEN_H=120, SPR_W/SPR_H defaults, N_PLANES. The enemy controller uses the same package.
- Sub-module sprite_pixel_counter:
  - Clear/enable inputs; dx/dy outputs and a last flag.
  - Counts dx 0..SPR_W-1, then dy 0..SPR_H-1.
- The FSM, snapshot registers and plane mux stay in enemy_plotter.

Test Plan:
- Draw, plane 0 only at (10,20) colour 111, others 000 → 16 plot pulses covering x=10..13, y=20..23 in row-major order, colour 7; done in cycle 27; busy high in cycles 1-27.
- Draw, all vis = 000 → no plot pulses; LOAD in cycles 1-10; done in cycle 11.
- Draw, plane 3 at (158,118) → exactly 4 plot pulses at (158,118), (159,118), (158,119), (159,119); plot=0 on the other 12 cycles; done still in cycle 27.
- Draw plane 0 at (10,20), then change y_flat[7:0] to 22 and issue erase → 16 plot pulses with colour 000 at rows 20..23, not 22..25.
- start pulsed again in cycle 5 of a pass → ignored; exactly one done, with the original pass timing.
- reset_n=0 at cycle 8 of a one-plane draw → plot=0 from cycle 9, no done; next start is accepted normally, and an erase then draws nothing.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy subsystem: colour codes, screen geometry,
// sprite defaults and the plotter pass states.
package enemy_pkg;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int SPR_W_DEFAULT    = 4;
    localparam int SPR_H_DEFAULT    = 4;
    localparam int N_PLANES_DEFAULT = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLOT,
        S_DONE
    } plotState_t;

    // Bounds test on 9-bit sums so a sprite hanging off the right/bottom edge
    // is clipped instead of wrapping around to the other side.
    function automatic logic onScreen(input logic [8:0] px, input logic [8:0] py,
                                      input int xMax, input int yMax);
        return (int'(px) < xMax) && (int'(py) < yMax);
    endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Walks a SPR_W x SPR_H sprite in row-major order (dx fastest) and flags the
// final pixel so the plotter knows when a plane is finished.
module sprite_pixel_counter #(
    parameter int SPR_W = 4,
    parameter int SPR_H = 4,
    localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear_i,
    input  logic           enable_i,
    output logic [DXW-1:0] dx_o,
    output logic [DYW-1:0] dy_o,
    output logic           last_o
);

    localparam logic [DXW-1:0] DX_LAST = DXW'(SPR_W - 1);
    localparam logic [DYW-1:0] DY_LAST = DYW'(SPR_H - 1);

    logic [DXW-1:0] dx_q, dx_d;
    logic [DYW-1:0] dy_q, dy_d;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (enable_i) begin
            if (dx_q == DX_LAST) begin
                dx_d = '0;
                dy_d = (dy_q == DY_LAST) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = (dx_q == DX_LAST) && (dy_q == DY_LAST);

endmodule

// File: rtl/enemy_plotter.sv
// Rasterises every present enemy plane as a sprite block into the VGA write
// port, one draw or erase pass per start pulse, finishing with a done pulse.
module enemy_plotter
    import enemy_pkg::*;
#(
    parameter int N_PLANES = N_PLANES_DEFAULT,
    parameter int SPR_W    = SPR_W_DEFAULT,
    parameter int SPR_H    = SPR_H_DEFAULT,
    parameter int X_MAX    = SCREEN_W,
    parameter int Y_MAX    = SCREEN_H
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  erase,
    input  logic [8*N_PLANES-1:0] x_flat,
    input  logic [8*N_PLANES-1:0] y_flat,
    input  logic [3*N_PLANES-1:0] vis_flat,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [2:0]            vga_colour,
    output logic                  plot
);

    localparam int IW  = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
    localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [IW-1:0] LAST_PLANE = IW'(N_PLANES - 1);

    // Snapshot taken on draw; erase replays it so y may move between passes.
    logic [7:0] xSnap_q   [N_PLANES];
    logic [7:0] ySnap_q   [N_PLANES];
    logic [2:0] visSnap_q [N_PLANES];

    plotState_t    state_q;
    logic [IW-1:0] plane_q;
    logic          eraseMode_q;
    logic          busy_q;
    logic          done_q;

    logic           cntClear;
    logic           cntEnable;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic           cntLast;

    logic [7:0] curX;
    logic [7:0] curY;
    logic [2:0] curVis;
    logic [8:0] sumX;
    logic [8:0] sumY;
    logic       inPlot;

    assign cntClear  = (state_q == S_LOAD);
    assign cntEnable = (state_q == S_PLOT);

    sprite_pixel_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .dx_o     (dx),
        .dy_o     (dy),
        .last_o   (cntLast)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            plane_q     <= '0;
            eraseMode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < N_PLANES; i++) begin
                xSnap_q[i]   <= '0;
                ySnap_q[i]   <= '0;
                visSnap_q[i] <= COLOUR_BLACK;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        plane_q     <= '0;
                        eraseMode_q <= erase;
                        busy_q      <= 1'b1;
                        if (!erase) begin
                            for (int i = 0; i < N_PLANES; i++) begin
                                xSnap_q[i]   <= x_flat[8*i +: 8];
                                ySnap_q[i]   <= y_flat[8*i +: 8];
                                visSnap_q[i] <= vis_flat[3*i +: 3];
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (visSnap_q[plane_q] == COLOUR_BLACK) begin
                        if (plane_q == LAST_PLANE) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            plane_q <= plane_q + 1'b1;
                        end
                    end else begin
                        state_q <= S_PLOT;
                    end
                end
                S_PLOT: begin
                    if (cntLast) begin
                        if (plane_q == LAST_PLANE) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            plane_q <= plane_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign curX   = xSnap_q[plane_q];
    assign curY   = ySnap_q[plane_q];
    assign curVis = visSnap_q[plane_q];
    assign sumX   = {1'b0, curX} + 9'(dx);
    assign sumY   = {1'b0, curY} + 9'(dy);
    assign inPlot = (state_q == S_PLOT);

    // Clipped pixels still take their cycle; only the write strobe is gated.
    assign vga_x      = inPlot ? sumX[7:0] : 8'd0;
    assign vga_y      = inPlot ? sumY[6:0] : 7'd0;
    assign vga_colour = !inPlot ? COLOUR_BLACK : (eraseMode_q ? COLOUR_BLACK : curVis);
    assign plot       = inPlot && onScreen(sumX, sumY, X_MAX, Y_MAX);

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_enemy_plotter.sv
// Self-checking bench for enemy_plotter: table of passes plus hand-written
// erase, restart and abort sequences, with a pixel scoreboard queue.
module tb_enemy_plotter;

    localparam int N = 10;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             erase;
    logic [8*N-1:0]   x_flat;
    logic [8*N-1:0]   y_flat;
    logic [3*N-1:0]   vis_flat;
    logic             busy;
    logic             done;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             plot;

    enemy_plotter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .erase      (erase),
        .x_flat     (x_flat),
        .y_flat     (y_flat),
        .vis_flat   (vis_flat),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8*N-1:0] xv;
        logic [8*N-1:0] yv;
        logic [3*N-1:0] vv;
        logic           er;
        int             expDone;
        int             expPlots;
        string          nm;
    } vec_t;

    vec_t vecs[6];
    int   expQ[$];
    int   mX[N];
    int   mY[N];
    int   mVis[N];
    int   nChecks;
    int   nFails;

    task automatic checkOutput(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: snapshot on draw, then list every on-screen pixel.
    task automatic buildExpected(input logic [8*N-1:0] xv, input logic [8*N-1:0] yv,
                                 input logic [3*N-1:0] vv, input logic er);
        expQ.delete();
        if (!er) begin
            for (int i = 0; i < N; i++) begin
                mX[i]   = int'(xv[8*i +: 8]);
                mY[i]   = int'(yv[8*i +: 8]);
                mVis[i] = int'(vv[3*i +: 3]);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mVis[i] != 0) begin
                for (int dy = 0; dy < 4; dy++) begin
                    for (int dx = 0; dx < 4; dx++) begin
                        int sx = mX[i] + dx;
                        int sy = mY[i] + dy;
                        if (sx < 160 && sy < 120)
                            expQ.push_back((sx << 16) | (sy << 8) | (er ? 0 : mVis[i]));
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [8*N-1:0] xv, input logic [8*N-1:0] yv,
                                 input logic [3*N-1:0] vv, input logic er,
                                 input int expDone, input int expPlots,
                                 input int restartAt, input int abortAt, input string nm);
        int doneCyc;
        int doneCount;
        int plots;
        int busyBad;
        int got;
        int want;
        buildExpected(xv, yv, vv, er);
        @(negedge clk);
        x_flat = xv; y_flat = yv; vis_flat = vv; erase = er; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        doneCyc = -1; doneCount = 0; plots = 0; busyBad = 0;
        for (int cyc = 1; cyc <= expDone + 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (abortAt > 0 && cyc == abortAt + 1) begin
                checkOutput({nm, "_plot_after_reset"}, int'(plot), 0);
                expQ.delete();
                for (int i = 0; i < N; i++) mVis[i] = 0;
                reset_n = 1'b1;
            end
            if (plot) begin
                plots++;
                got = (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour);
                if (expQ.size() == 0) begin
                    checkOutput({nm, "_unexpected_pixel"}, got, -1);
                end else begin
                    want = expQ.pop_front();
                    checkOutput({nm, "_pixel"}, got, want);
                end
            end
            if (abortAt == 0 || cyc <= abortAt) begin
                if (doneCyc < 0 && !busy) busyBad++;
                if (doneCyc > 0 && cyc == doneCyc + 1 && busy) busyBad++;
            end
            if (done) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            start = (cyc == restartAt);
            if (abortAt > 0 && cyc == abortAt) reset_n = 1'b0;
        end
        start = 1'b0;
        checkOutput({nm, "_done_cycle"}, doneCyc, (expDone == 0) ? -1 : expDone);
        checkOutput({nm, "_done_count"}, doneCount, (expDone == 0) ? 0 : 1);
        checkOutput({nm, "_plot_count"}, plots, expPlots);
        checkOutput({nm, "_busy_window"}, busyBad, 0);
        checkOutput({nm, "_pixels_left"}, expQ.size(), 0);
    endtask

    initial begin
        logic [8*N-1:0] xv;
        logic [8*N-1:0] yv;
        logic [3*N-1:0] vv;
        nChecks = 0;
        nFails  = 0;
        for (int i = 0; i < N; i++) begin
            mX[i] = 0; mY[i] = 0; mVis[i] = 0;
        end

        // Reset held while start is asserted: reset must win.
        reset_n = 1'b0; start = 1'b1; erase = 1'b0;
        x_flat = '0; y_flat = '0; vis_flat = '1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_plot", int'(plot), 0);
        checkOutput("reset_vga", (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour), 0);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);

        xv = '0; yv = '0; vv = '0;
        xv[0 +: 8] = 8'd10; yv[0 +: 8] = 8'd20; vv[0 +: 3] = 3'd7;
        vecs[0] = '{xv, yv, vv, 1'b0, 27, 16, "one_plane"};
        vecs[1] = '{'0, '0, '0, 1'b0, 11, 0, "all_black"};
        xv = '0; yv = '0; vv = '0;
        xv[24 +: 8] = 8'd158; yv[24 +: 8] = 8'd118; vv[9 +: 3] = 3'd3;
        vecs[2] = '{xv, yv, vv, 1'b0, 27, 4, "clip_corner"};
        xv = '0; yv = '0; vv = '0;
        vv[6 +: 3] = 3'd2;
        xv[72 +: 8] = 8'd40; yv[72 +: 8] = 8'd100; vv[27 +: 3] = 3'd4;
        vecs[3] = '{xv, yv, vv, 1'b0, 43, 32, "two_planes"};
        xv = '0; yv = '0; vv = '0;
        xv[8 +: 8] = 8'd254; yv[8 +: 8] = 8'd10; vv[3 +: 3] = 3'd1;
        xv[40 +: 8] = 8'd157; yv[40 +: 8] = 8'd50; vv[15 +: 3] = 3'd6;
        vecs[4] = '{xv, yv, vv, 1'b0, 43, 12, "clip_x_wrap"};
        vecs[5] = '{'0, '1, '0, 1'b1, 43, 12, "erase_snapshot"};

        for (int v = 0; v < 6; v++)
            applyStimulus(vecs[v].xv, vecs[v].yv, vecs[v].vv, vecs[v].er,
                          vecs[v].expDone, vecs[v].expPlots, 0, 0, vecs[v].nm);

        // Draw, move y, then erase: erase must use the old rows.
        xv = '0; yv = '0; vv = '0;
        xv[0 +: 8] = 8'd10; yv[0 +: 8] = 8'd20; vv[0 +: 3] = 3'd7;
        applyStimulus(xv, yv, vv, 1'b0, 27, 16, 0, 0, "draw_before_erase");
        yv[0 +: 8] = 8'd22;
        applyStimulus(xv, yv, vv, 1'b1, 27, 16, 0, 0, "erase_old_y");

        // Second start mid-pass is dropped.
        yv[0 +: 8] = 8'd20;
        applyStimulus(xv, yv, vv, 1'b0, 27, 16, 5, 0, "restart_ignored");

        // Abort with reset in cycle 8, then an erase finds nothing to erase.
        applyStimulus(xv, yv, vv, 1'b0, 0, 7, 0, 8, "abort_draw");
        applyStimulus(xv, yv, vv, 1'b1, 11, 0, 0, 0, "erase_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
